// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } state_t;

  localparam int unsigned LOSS_CNT_W = 8;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL locked flag into clk.
module pll_lock_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Two-stage capture; both flops clear to 0 so lock is never assumed at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, then releases staged fabric resets.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned NUM_STAGES          = 3,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STAGE_GAP_CYCLES    = 64,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  all_ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic                  fail
);

  localparam int unsigned REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP_CYCLES;
  localparam int unsigned MAX_AB   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD   = (LOCK_TIMEOUT_CYCLES > REL_SPAN) ?
                                     LOCK_TIMEOUT_CYCLES : REL_SPAN;
  localparam int unsigned CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W    = cnt_width(CNT_MAX);
  localparam int unsigned RETRY_W  = cnt_width(MAX_RETRIES);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(REL_SPAN);
  localparam logic [RETRY_W:0] RETRY_LIMIT  = (RETRY_W + 1)'(MAX_RETRIES);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [RETRY_W-1:0]      retry, retry_next;
  logic [RETRY_W:0]        retry_inc;
  logic                    loss_event;
  logic                    lock_s;

  logic                    pll_rst_d;
  logic [NUM_STAGES-1:0]   stage_d;
  logic                    all_ready_d;
  logic                    fail_d;
  logic [LOSS_CNT_W-1:0]   loss_cnt_d;

  pll_lock_sync u_lock_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  assign retry_inc = {1'b0, retry} + 1'b1;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= PLL_RST;
      cnt             <= '0;
      retry           <= '0;
      pll_rst         <= 1'b1;
      stage_reset_n   <= '0;
      all_ready       <= 1'b0;
      fail            <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      retry           <= retry_next;
      pll_rst         <= pll_rst_d;
      stage_reset_n   <= stage_d;
      all_ready       <= all_ready_d;
      fail            <= fail_d;
      lock_loss_count <= loss_cnt_d;
    end
  end

  // Next-state and counter logic; lock loss takes priority over soft reset.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retry;
    loss_event = 1'b0;
    unique case (state)
      PLL_RST: begin
        if (cnt == PLL_RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retry != '1) retry_next = retry_inc[RETRY_W-1:0];
          if ((MAX_RETRIES != 0) && (retry_inc == RETRY_LIMIT)) state_next = FAIL;
          else                                                   state_next = PLL_RST;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RELEASE;
          cnt_next   = '0;
          retry_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          state_next = PLL_RST;
          cnt_next   = '0;
          loss_event = 1'b1;
        end else if (soft_reset_req) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (state == RELEASE) begin
          if (cnt == REL_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      FAIL: begin
        state_next = FAIL;
      end
      default: begin
        state_next = PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is heading
  // so every output lines up with the state register.
  always_comb begin
    pll_rst_d   = (state_next == PLL_RST) || (state_next == FAIL);
    all_ready_d = (state_next == RUN);
    fail_d      = (state_next == FAIL);
    stage_d     = '0;
    if (state_next == RUN) begin
      stage_d = '1;
    end else if (state_next == RELEASE) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_d[i] = (cnt_next >= CNT_W'(i * STAGE_GAP_CYCLES));
      end
    end
    loss_cnt_d = lock_loss_count;
    if (loss_event && (lock_loss_count != '1)) loss_cnt_d = lock_loss_count + 1'b1;
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: expected output changes are queued per scenario and
// matched against the changes seen on the DUT outputs, cycle by cycle.
module tb_pll_reset_sequencer;

  typedef struct packed {
    int          cyc;
    logic [13:0] v;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       pll_rst;
  logic [2:0] stage_reset_n;
  logic       all_ready;
  logic [7:0] lock_loss_count;
  logic       fail;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          rel;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [13:0] prev;

  localparam logic [13:0] RST_V = {1'b1, 3'b000, 1'b0, 1'b0, 8'd0};

  pll_reset_sequencer #(
    .NUM_STAGES          (3),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .STAGE_GAP_CYCLES    (2),
    .MAX_RETRIES         (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .soft_reset_req  (soft_reset_req),
    .pll_rst         (pll_rst),
    .stage_reset_n   (stage_reset_n),
    .all_ready       (all_ready),
    .lock_loss_count (lock_loss_count),
    .fail            (fail)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] out_vec();
    return {pll_rst, stage_reset_n, all_ready, fail, lock_loss_count};
  endfunction

  task automatic expect_ev(input int c, input logic pr, input logic [2:0] st,
                           input logic rd, input logic fl, input logic [7:0] llc);
    ev_t e;
    e.cyc = c;
    e.v   = {pr, st, rd, fl, llc};
    exp_q.push_back(e);
  endtask

  // Stable qualification entered at cycle s: 8 stable cycles, then stages 2 apart.
  task automatic push_release(input int s, input logic [7:0] llc);
    expect_ev(s + 8,  1'b0, 3'b001, 1'b0, 1'b0, llc);
    expect_ev(s + 10, 1'b0, 3'b011, 1'b0, 1'b0, llc);
    expect_ev(s + 12, 1'b0, 3'b111, 1'b0, 1'b0, llc);
    expect_ev(s + 13, 1'b0, 3'b111, 1'b1, 1'b0, llc);
  endtask

  // Advance to the falling edge after rising edge n, logging output changes.
  task automatic run_until(input int n);
    ev_t o;
    while (rel < n) begin
      @(posedge clk);
      rel++;
      @(negedge clk);
      if (out_vec() !== prev) begin
        o.cyc = rel;
        o.v   = out_vec();
        obs_q.push_back(o);
        prev = out_vec();
      end
    end
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    prev    = RST_V;
    rel     = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_vec() !== RST_V) begin
      n_bad++;
      $display("FAIL reset_values: got %h, expected %h", out_vec(), RST_V);
    end
  endtask

  task automatic test_nominal();
    ev_t e, o;
    apply_reset();
    expect_ev(4, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    push_release(9, 8'd0);
    run_until(6);
    pll_locked = 1'b1;
    run_until(40);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '{cyc: -1, v: 14'h0};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '{cyc: -1, v: 14'h0};
      n_cmp++;
      if (o.cyc !== e.cyc || o.v !== e.v) begin
        n_bad++;
        $display("FAIL nominal: got cyc %0d out %h, expected cyc %0d out %h", o.cyc, o.v, e.cyc, e.v);
      end
    end
  endtask

  task automatic test_timeout();
    ev_t e, o;
    apply_reset();
    expect_ev(4,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    expect_ev(36, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
    expect_ev(40, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    expect_ev(72, 1'b1, 3'b000, 1'b0, 1'b1, 8'd0);
    run_until(80);
    pll_locked = 1'b1;
    run_until(110);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '{cyc: -1, v: 14'h0};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '{cyc: -1, v: 14'h0};
      n_cmp++;
      if (o.cyc !== e.cyc || o.v !== e.v) begin
        n_bad++;
        $display("FAIL timeout: got cyc %0d out %h, expected cyc %0d out %h", o.cyc, o.v, e.cyc, e.v);
      end
    end
  endtask

  task automatic test_unstable();
    ev_t e, o;
    apply_reset();
    expect_ev(4, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    push_release(19, 8'd0);
    run_until(6);
    pll_locked = 1'b1;
    run_until(11);
    pll_locked = 1'b0;
    run_until(16);
    pll_locked = 1'b1;
    run_until(45);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '{cyc: -1, v: 14'h0};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '{cyc: -1, v: 14'h0};
      n_cmp++;
      if (o.cyc !== e.cyc || o.v !== e.v) begin
        n_bad++;
        $display("FAIL unstable: got cyc %0d out %h, expected cyc %0d out %h", o.cyc, o.v, e.cyc, e.v);
      end
    end
  endtask

  task automatic test_lock_loss();
    ev_t e, o;
    apply_reset();
    expect_ev(4, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    push_release(9, 8'd0);
    expect_ev(33, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
    expect_ev(37, 1'b0, 3'b000, 1'b0, 1'b0, 8'd1);
    push_release(38, 8'd1);
    run_until(6);
    pll_locked = 1'b1;
    run_until(30);
    pll_locked = 1'b0;
    run_until(33);
    pll_locked = 1'b1;
    run_until(65);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '{cyc: -1, v: 14'h0};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '{cyc: -1, v: 14'h0};
      n_cmp++;
      if (o.cyc !== e.cyc || o.v !== e.v) begin
        n_bad++;
        $display("FAIL lock_loss: got cyc %0d out %h, expected cyc %0d out %h", o.cyc, o.v, e.cyc, e.v);
      end
    end
  endtask

  task automatic test_soft_reset();
    ev_t e, o;
    apply_reset();
    expect_ev(4, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    push_release(9, 8'd0);
    expect_ev(27, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    push_release(27, 8'd0);
    expect_ev(48, 1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
    expect_ev(52, 1'b0, 3'b000, 1'b0, 1'b0, 8'd1);
    push_release(53, 8'd1);
    run_until(6);
    pll_locked = 1'b1;
    run_until(26);
    soft_reset_req = 1'b1;
    run_until(27);
    soft_reset_req = 1'b0;
    run_until(45);
    pll_locked = 1'b0;
    run_until(47);
    soft_reset_req = 1'b1;
    run_until(48);
    soft_reset_req = 1'b0;
    run_until(49);
    pll_locked = 1'b1;
    run_until(80);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '{cyc: -1, v: 14'h0};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '{cyc: -1, v: 14'h0};
      n_cmp++;
      if (o.cyc !== e.cyc || o.v !== e.v) begin
        n_bad++;
        $display("FAIL soft_reset: got cyc %0d out %h, expected cyc %0d out %h", o.cyc, o.v, e.cyc, e.v);
      end
    end
  endtask

  task automatic test_async_reset();
    ev_t e, o;
    apply_reset();
    expect_ev(4, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    expect_ev(17, 1'b0, 3'b001, 1'b0, 1'b0, 8'd0);
    run_until(6);
    pll_locked = 1'b1;
    run_until(17);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '{cyc: -1, v: 14'h0};
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '{cyc: -1, v: 14'h0};
      n_cmp++;
      if (o.cyc !== e.cyc || o.v !== e.v) begin
        n_bad++;
        $display("FAIL async_pre: got cyc %0d out %h, expected cyc %0d out %h", o.cyc, o.v, e.cyc, e.v);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_vec() !== RST_V) begin
      n_bad++;
      $display("FAIL async_immediate: got %h, expected %h", out_vec(), RST_V);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_vec() !== RST_V) begin
      n_bad++;
      $display("FAIL async_held: got %h, expected %h", out_vec(), RST_V);
    end
  endtask

  initial begin
    rel  = 0;
    prev = RST_V;
    test_reset();
    test_nominal();
    test_timeout();
    test_unstable();
    test_lock_loss();
    test_soft_reset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
